// File: rtl/cpu_plic_claim.sv
// CPU-side claim/complete initiator for the platform interrupt controller.
// Optional bus-ready timeout: define CPU_PLIC_CLAIM_TIMEOUT_EN.
module cpu_plic_claim #(
    parameter logic [23:0] ENABLE_ADDRESS   = 24'h002000,
    parameter logic [23:0] CLAIM_ADDRESS    = 24'h200004,
    parameter logic [23:0] COMPLETE_ADDRESS = 24'h200004,
    parameter logic [3:0]  ENABLE_MASK      = 4'b1111,
    parameter int unsigned ID_WIDTH         = 3,
    parameter int unsigned TIMEOUT          = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_interrupt,
    output logic                o_bus_request,
    output logic                o_bus_rw,
    output logic [23:0]         o_bus_address,
    output logic [31:0]         o_bus_wdata,
    input  logic [31:0]         i_bus_rdata,
    input  logic                i_bus_ready,
    output logic                o_irq,
    output logic [ID_WIDTH-1:0] o_irq_id,
    input  logic                i_irq_ack,
    input  logic                i_irq_complete,
    output logic                o_busy,
    output logic                o_error
);

    typedef enum logic [2:0] {
        S_INIT,
        S_INIT_WAIT,
        S_IDLE,
        S_CLAIM_WAIT,
        S_DELIVER,
        S_SERVICE,
        S_COMPLETE,
        S_COMPLETE_WAIT
    } state_t;

    state_t              state, state_next;
    logic                pending, pending_next;
    logic                request_next, rw_next, irq_next, busy_next;
    logic [23:0]         address_next;
    logic [31:0]         wdata_next;
    logic [ID_WIDTH-1:0] id_next;
    logic [ID_WIDTH-1:0] claimed_id;
    logic                waiting;
    logic                unused_rdata_hi;

    assign claimed_id      = i_bus_rdata[ID_WIDTH-1:0];
    assign unused_rdata_hi = ^i_bus_rdata[31:ID_WIDTH];
    assign waiting         = (state == S_INIT_WAIT) || (state == S_CLAIM_WAIT) ||
                             (state == S_COMPLETE_WAIT);

`ifdef CPU_PLIC_CLAIM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] wait_count, wait_count_next;
    logic          error_next;
`else
    logic          unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign o_error        = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        pending_next = pending | (i_interrupt && (state != S_IDLE));
        request_next = 1'b0;
        rw_next      = o_bus_rw;
        address_next = o_bus_address;
        wdata_next   = o_bus_wdata;
        irq_next     = o_irq;
        id_next      = o_irq_id;

        case (state)
            S_INIT: begin
                request_next = 1'b1;
                rw_next      = 1'b1;
                address_next = ENABLE_ADDRESS;
                wdata_next   = {27'b0, ENABLE_MASK, 1'b0};
                state_next   = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (i_bus_ready) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (i_interrupt || pending) begin
                    pending_next = 1'b0;
                    request_next = 1'b1;
                    rw_next      = 1'b0;
                    address_next = CLAIM_ADDRESS;
                    state_next   = S_CLAIM_WAIT;
                end
            end
            S_CLAIM_WAIT: begin
                if (i_bus_ready) begin
                    if (claimed_id != '0) begin
                        irq_next   = 1'b1;
                        id_next    = claimed_id;
                        state_next = S_DELIVER;
                    end else begin
                        state_next = S_COMPLETE;
                    end
                end
            end
            S_DELIVER: begin
                // complete wins over ack so a handler that never acks still releases the source
                if (i_irq_complete) begin
                    irq_next   = 1'b0;
                    state_next = S_COMPLETE;
                end else if (i_irq_ack) begin
                    irq_next   = 1'b0;
                    state_next = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (i_irq_complete) state_next = S_COMPLETE;
            end
            S_COMPLETE: begin
                request_next = 1'b1;
                rw_next      = 1'b1;
                address_next = COMPLETE_ADDRESS;
                wdata_next   = 32'(o_irq_id);
                state_next   = S_COMPLETE_WAIT;
            end
            S_COMPLETE_WAIT: begin
                if (i_bus_ready) begin
                    id_next    = '0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_INIT;
        endcase

`ifdef CPU_PLIC_CLAIM_TIMEOUT_EN
        error_next      = o_error;
        wait_count_next = wait_count;
        if (waiting && !i_bus_ready) begin
            if (wait_count == CW'(TIMEOUT - 1)) begin
                error_next = 1'b1;
                state_next = S_IDLE;
                irq_next   = 1'b0;
                id_next    = '0;
            end else begin
                wait_count_next = wait_count + 1'b1;
            end
        end
        if (request_next) wait_count_next = '0;
`endif

        // registered so o_busy reads 0 during reset, yet tracks the state afterwards
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state         <= S_INIT;
            pending       <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_irq         <= 1'b0;
            o_irq_id      <= '0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_next;
            pending       <= pending_next;
            o_bus_request <= request_next;
            o_bus_rw      <= rw_next;
            o_bus_address <= address_next;
            o_bus_wdata   <= wdata_next;
            o_irq         <= irq_next;
            o_irq_id      <= id_next;
            o_busy        <= busy_next;
        end
    end

`ifdef CPU_PLIC_CLAIM_TIMEOUT_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            wait_count <= '0;
            o_error    <= 1'b0;
        end else begin
            wait_count <= wait_count_next;
            o_error    <= error_next;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_plic_claim.sv
// Directed bench for cpu_plic_claim: cycle table plus hand-written corner sequences.
// Timeout checks are compiled when CPU_PLIC_CLAIM_TIMEOUT_EN is defined.
module tb_cpu_plic_claim;

    localparam logic [23:0] A_EN = 24'h002000;
    localparam logic [23:0] A_CL = 24'h200004;

    logic        clk = 1'b0;
    logic        rst_n, intr, rdy, ack, cmp;
    logic [31:0] rdata;
    logic        bus_req, bus_rw, irq, busy, err;
    logic [23:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  irq_id;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_plic_claim #(
        .ENABLE_ADDRESS   (24'h002000),
        .CLAIM_ADDRESS    (24'h200004),
        .COMPLETE_ADDRESS (24'h200004),
        .ENABLE_MASK      (4'b1111),
        .ID_WIDTH         (3),
        .TIMEOUT          (16)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_interrupt    (intr),
        .o_bus_request  (bus_req),
        .o_bus_rw       (bus_rw),
        .o_bus_address  (bus_addr),
        .o_bus_wdata    (bus_wdata),
        .i_bus_rdata    (rdata),
        .i_bus_ready    (rdy),
        .o_irq          (irq),
        .o_irq_id       (irq_id),
        .i_irq_ack      (ack),
        .i_irq_complete (cmp),
        .o_busy         (busy),
        .o_error        (err)
    );

    typedef struct {
        logic        rst_n, intr, rdy;
        logic [31:0] rdata;
        logic        ack, cmp;
        logic        e_req, e_rw;
        logic [23:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_irq;
        logic [2:0]  e_id;
        logic        e_busy;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // bus fields are only meaningful in the request cycle; wdata only for writes
    task automatic check_outs(input string tag, input logic e_req, input logic e_rw,
                              input logic [23:0] e_addr, input logic [31:0] e_wdata,
                              input logic e_irq, input logic [2:0] e_id,
                              input logic e_busy, input logic e_err);
        chk({tag, ".req"}, 32'(bus_req), 32'(e_req));
        chk({tag, ".irq"}, 32'(irq), 32'(e_irq));
        chk({tag, ".id"}, 32'(irq_id), 32'(e_id));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        if (e_req) begin
            chk({tag, ".rw"}, 32'(bus_rw), 32'(e_rw));
            chk({tag, ".addr"}, 32'(bus_addr), 32'(e_addr));
            if (e_rw) chk({tag, ".wdata"}, bus_wdata, e_wdata);
        end
    endtask

    // drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic cyc(input logic r, input logic i, input logic rd, input logic [31:0] d,
                       input logic a, input logic c);
        rst_n = r; intr = i; rdy = rd; rdata = d; ack = a; cmp = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; intr = 1'b0; rdy = 1'b0; rdata = '0; ack = 1'b0; cmp = 1'b0;

        //            rst int rdy rdata          ack cmp  req rw addr  wdata    irq id busy
        tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_EN,32'h0,  1'b0,3'd0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b1,A_EN,32'h1E, 1'b0,3'd0,1'b1};
        tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_EN,32'h0,  1'b0,3'd0,1'b1};
        tbl[3]  = '{1'b1,1'b0,1'b1,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_EN,32'h0,  1'b0,3'd0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b1};
        tbl[5]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b1};
        tbl[6]  = '{1'b1,1'b0,1'b1,32'h2,        1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b1,3'd2,1'b1};
        tbl[7]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b1,3'd2,1'b1};
        tbl[8]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd2,1'b1};
        tbl[9]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd2,1'b1};
        tbl[10] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b1,A_CL,32'h2,  1'b0,3'd2,1'b1};
        tbl[11] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd2,1'b1};
        tbl[12] = '{1'b1,1'b0,1'b1,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b0};
        tbl[13] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b1};
        tbl[14] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b1};
        tbl[15] = '{1'b1,1'b0,1'b1,32'hFFFF_FFF8,1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b1};
        tbl[16] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b1,A_CL,32'h0,  1'b0,3'd0,1'b1};
        tbl[17] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b1};
        tbl[18] = '{1'b1,1'b0,1'b1,32'h0,        1'b0,1'b0, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b0};
        tbl[19] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1, 1'b0,1'b0,A_CL,32'h0,  1'b0,3'd0,1'b0};

        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 20; k++) begin
            cyc(tbl[k].rst_n, tbl[k].intr, tbl[k].rdy, tbl[k].rdata, tbl[k].ack, tbl[k].cmp);
            check_outs($sformatf("row%0d", k), tbl[k].e_req, tbl[k].e_rw, tbl[k].e_addr,
                       tbl[k].e_wdata, tbl[k].e_irq, tbl[k].e_id, tbl[k].e_busy, 1'b0);
        end

        // pulses during SERVICE merge into one deferred claim; complete in DELIVER without ack
        cyc(1, 1, 0, 32'h0, 0, 0); check_outs("pend.claim1", 1, 0, A_CL, 0, 0, 3'd0, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("pend.wait1",  0, 0, A_CL, 0, 0, 3'd0, 1, 0);
        cyc(1, 0, 1, 32'h1, 0, 0); check_outs("pend.irq1",   0, 0, A_CL, 0, 1, 3'd1, 1, 0);
        cyc(1, 0, 0, 32'h0, 1, 0); check_outs("pend.ack1",   0, 0, A_CL, 0, 0, 3'd1, 1, 0);
        cyc(1, 1, 0, 32'h0, 0, 0); check_outs("pend.int_a",  0, 0, A_CL, 0, 0, 3'd1, 1, 0);
        cyc(1, 0, 0, 32'h0, 1, 0); check_outs("pend.ack_ign",0, 0, A_CL, 0, 0, 3'd1, 1, 0);
        cyc(1, 1, 0, 32'h0, 0, 0); check_outs("pend.int_b",  0, 0, A_CL, 0, 0, 3'd1, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 1); check_outs("pend.cmp1",   0, 0, A_CL, 0, 0, 3'd1, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("pend.wr1",    1, 1, A_CL, 32'h1, 0, 3'd1, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("pend.wr1w",   0, 0, A_CL, 0, 0, 3'd1, 1, 0);
        cyc(1, 0, 1, 32'h0, 0, 0); check_outs("pend.idle",   0, 0, A_CL, 0, 0, 3'd0, 0, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("pend.claim2", 1, 0, A_CL, 0, 0, 3'd0, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("pend.wait2",  0, 0, A_CL, 0, 0, 3'd0, 1, 0);
        cyc(1, 0, 1, 32'h3, 0, 0); check_outs("pend.irq3",   0, 0, A_CL, 0, 1, 3'd3, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 1); check_outs("dlv.cmp",     0, 0, A_CL, 0, 0, 3'd3, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("dlv.wr3",     1, 1, A_CL, 32'h3, 0, 3'd3, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("dlv.wr3w",    0, 0, A_CL, 0, 0, 3'd3, 1, 0);
        cyc(1, 0, 1, 32'h0, 0, 0); check_outs("dlv.idle",    0, 0, A_CL, 0, 0, 3'd0, 0, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("dlv.noclaim", 0, 0, A_CL, 0, 0, 3'd0, 0, 0);

        // reset in CLAIM_WAIT abandons the transfer; the enable write repeats
        cyc(1, 1, 0, 32'h0, 0, 0); check_outs("rst.claim",   1, 0, A_CL, 0, 0, 3'd0, 1, 0);
        cyc(0, 0, 1, 32'h4, 0, 0); check_outs("rst.zero",    0, 0, A_CL, 0, 0, 3'd0, 0, 0);
        cyc(0, 1, 0, 32'h0, 0, 0); check_outs("rst.hold",    0, 0, A_CL, 0, 0, 3'd0, 0, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("rst.enable",  1, 1, A_EN, 32'h1E, 0, 3'd0, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("rst.enw",     0, 0, A_EN, 0, 0, 3'd0, 1, 0);
        cyc(1, 0, 1, 32'h0, 0, 0); check_outs("rst.idle",    0, 0, A_EN, 0, 0, 3'd0, 0, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("rst.nopend",  0, 0, A_EN, 0, 0, 3'd0, 0, 0);

`ifdef CPU_PLIC_CLAIM_TIMEOUT_EN
        cyc(1, 1, 0, 32'h0, 0, 0); check_outs("to.claim",    1, 0, A_CL, 0, 0, 3'd0, 1, 0);
        for (int w = 0; w < 15; w++) cyc(1, 0, 0, 32'h0, 0, 0);
        check_outs("to.before",   0, 0, A_CL, 0, 0, 3'd0, 1, 0);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("to.expire",   0, 0, A_CL, 0, 0, 3'd0, 0, 1);
        cyc(1, 0, 1, 32'h2, 0, 0); check_outs("to.late_rdy", 0, 0, A_CL, 0, 0, 3'd0, 0, 1);
        cyc(1, 0, 0, 32'h0, 0, 0); check_outs("to.sticky",   0, 0, A_CL, 0, 0, 3'd0, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
